// File: rtl/riscv_muldiv_unit.sv
// ---------------------------------------------------------------------------
// riscv_muldiv_unit
//
// Iterative RV32M execution unit. Takes the 5-bit M-function code
// {instr[30], instr[25], instr[14:12]} plus rs1/rs2, computes the result one
// bit per cycle (shift-add multiply, restoring divide) on operand magnitudes,
// fixes the sign at the end, and hands the result to writeback over a
// valid/ready handshake.
//
// Divide-by-zero, signed overflow and illegal function codes are resolved
// when the request is accepted and go straight to DONE.
//
// Build option:
//   RISCV_MULDIV_FASTMUL_EN - when defined, all multiplies are computed in a
//                             single cycle at acceptance (IDLE -> DONE). The
//                             MUL state is then never entered.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   req_valid     request present
//   req_ready     unit can accept a request ((state == IDLE) && !kill)
//   req_func      {instr[30], instr[25], instr[14:12]}
//   req_rs1       operand A (dividend / multiplicand)
//   req_rs2       operand B (divisor / multiplier)
//   req_tag       destination tag carried with the op
//   kill          flush; abandons any in-flight op without a response
//   resp_valid    result available (state == DONE)
//   resp_ready    consumer takes the result
//   resp_result   result
//   resp_tag      tag of the returned op
//   resp_illegal  req_func was not an M code
//   busy          state != IDLE
// ---------------------------------------------------------------------------
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_func,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             kill,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_illegal,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);

  // funct3 encodings of the M extension
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Op context captured at acceptance
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_q;      // final result must be negated
  logic [XLEN-1:0]  opnd_q;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]  hi_q;       // product high half / partial remainder
  logic [XLEN-1:0]  lo_q;       // multiplier->product low half / dividend->quotient
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;

  // ------------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------------
  logic            accept;
  logic [2:0]      f3;
  logic            req_legal;
  logic            req_is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            res_neg;
  logic            div_zero, div_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;

  assign req_ready  = (state == S_IDLE) && !kill;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);

  assign f3         = req_func[2:0];
  assign req_legal  = (req_func[4:3] == 2'b01);
  assign req_is_div = f3[2];

  assign a_signed = (f3 == F_MULH) || (f3 == F_MULHSU) || (f3 == F_DIV) || (f3 == F_REM);
  assign b_signed = (f3 == F_MULH) || (f3 == F_DIV) || (f3 == F_REM);
  assign a_neg    = a_signed && req_rs1[XLEN-1];
  assign b_neg    = b_signed && req_rs2[XLEN-1];
  // INT_MIN negates to itself, which is also its correct unsigned magnitude.
  assign a_mag    = a_neg ? -req_rs1 : req_rs1;
  assign b_mag    = b_neg ? -req_rs2 : req_rs2;
  // Remainder takes the dividend's sign; quotient and product take the XOR.
  assign res_neg  = (f3 == F_REM) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = req_is_div && (req_rs2 == '0);
  assign div_ovf  = ((f3 == F_DIV) || (f3 == F_REM)) &&
                    (req_rs1 == INT_MIN) && (req_rs2 == '1);

`ifdef RISCV_MULDIV_FASTMUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  // Sign/zero-extending to 2*XLEN makes a truncated product exact for
  // every signedness combination.
  assign fast_a    = a_signed ? {{XLEN{req_rs1[XLEN-1]}}, req_rs1} : {{XLEN{1'b0}}, req_rs1};
  assign fast_b    = b_signed ? {{XLEN{req_rs2[XLEN-1]}}, req_rs2} : {{XLEN{1'b0}}, req_rs2};
  assign fast_prod = fast_a * fast_b;
`endif

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (!req_legal) begin
      special = 1'b1;
    end else if (div_zero) begin
      special        = 1'b1;
      special_result = f3[1] ? req_rs1 : '1;     // REM* : DIV*
    end else if (div_ovf) begin
      special        = 1'b1;
      special_result = f3[1] ? '0 : INT_MIN;
    end
`ifdef RISCV_MULDIV_FASTMUL_EN
    else if (!req_is_div) begin
      special        = 1'b1;
      special_result = (f3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // ------------------------------------------------------------------------
  // One iteration of the shared datapath
  // ------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   final_result;

  // Shift-add: add multiplicand when the current multiplier LSB is set, then
  // shift the whole {hi, lo} pair right; product bits fill lo from the top.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The difference is always below
  // the divisor, so XLEN bits hold it exactly.
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

  always_comb begin
    if (state == S_DIV) begin
      step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Result of the final iteration, sign-corrected and selected by op.
  always_comb begin
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quot_fix = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_q ? -step_hi : step_hi;
    case (op_q)
      F_MUL:                     final_result = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             final_result = quot_fix;
      default:                   final_result = rem_fix;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples pre-edge values regardless of block or statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (special)         state_nxt = S_DONE;
          else if (req_is_div) state_nxt = S_DIV;
          else                 state_nxt = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_W'(XLEN - 1);
      op_q      <= f3;
      neg_q     <= res_neg;
      tag_q     <= req_tag;
      illegal_q <= !req_legal;
      hi_q      <= '0;
      if (req_is_div) begin
        lo_q   <= a_mag;
        opnd_q <= b_mag;
      end else begin
        lo_q   <= b_mag;
        opnd_q <= a_mag;
      end
      if (special) result_q <= special_result;
    end else if ((state == S_MUL) || (state == S_DIV)) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
      if (cnt == '0) result_q <= final_result;
      else           cnt      <= cnt - CNT_W'(1);
    end
  end

  assign resp_result  = result_q;
  assign resp_tag     = tag_q;
  assign resp_illegal = illegal_q;

endmodule
